// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard/forwarding bundle between the controller (master) and hazard_scoreboard (slave).
// Counter signals exist only when HAZARD_SCOREBOARD_STATS_EN is defined.
interface hazard_scoreboard_if #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int FWD_WIDTH      = 2
);
    logic                      id_valid;
    logic [REG_ADDR_WIDTH-1:0] id_rs;
    logic [REG_ADDR_WIDTH-1:0] id_rt;
    logic                      id_useRs;
    logic                      id_useRt;
    logic                      id_regWrite;
    logic [REG_ADDR_WIDTH-1:0] id_regToWrite;
    logic                      id_memRead;
    logic                      id_branch;
    logic                      flush_req;
    logic                      stall;
    logic                      flush;
    logic [FWD_WIDTH-1:0]      id_fwd_rs;
    logic [FWD_WIDTH-1:0]      id_fwd_rt;
    logic [FWD_WIDTH-1:0]      ex_fwd_rs;
    logic [FWD_WIDTH-1:0]      ex_fwd_rt;

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0]               stall_count;
    logic [31:0]               flush_count;

    modport master (
        output id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite,
               id_regToWrite, id_memRead, id_branch, flush_req,
        input  stall, flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt,
               stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite,
               id_regToWrite, id_memRead, id_branch, flush_req,
        output stall, flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt,
               stall_count, flush_count
    );
`else
    modport master (
        output id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite,
               id_regToWrite, id_memRead, id_branch, flush_req,
        input  stall, flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_useRs, id_useRt, id_regWrite,
               id_regToWrite, id_memRead, id_branch, flush_req,
        output stall, flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt
    );
`endif
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard detection and forwarding control: shift-register scoreboard of in-flight destinations.
// Optional stall/flush event counters are enabled by defining HAZARD_SCOREBOARD_STATS_EN.
module hazard_scoreboard #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int PIPE_DEPTH     = 3,
    parameter int LOAD_LAT       = 2,
    parameter int FWD_WIDTH      = 2
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave sb_if
);

    logic [PIPE_DEPTH:1]                     v_q;
    logic [PIPE_DEPTH:1]                     v_d;
    logic [PIPE_DEPTH:1][REG_ADDR_WIDTH-1:0] rd_q;
    logic [PIPE_DEPTH:1][REG_ADDR_WIDTH-1:0] rd_d;
    logic [PIPE_DEPTH:1]                     ld_q;
    logic [PIPE_DEPTH:1]                     ld_d;

    logic [FWD_WIDTH-1:0] rs_match_s;
    logic [FWD_WIDTH-1:0] rt_match_s;
    logic                 rs_ld_s;
    logic                 rt_ld_s;
    logic                 stall_s;
    logic                 flush_s;
    logic [FWD_WIDTH-1:0] ex_fwd_rs_q;
    logic [FWD_WIDTH-1:0] ex_fwd_rs_d;
    logic [FWD_WIDTH-1:0] ex_fwd_rt_q;
    logic [FWD_WIDTH-1:0] ex_fwd_rt_d;

    // Youngest (lowest slot) producer wins; returns {ld flag, slot index}, index 0 = no match.
    function automatic logic [FWD_WIDTH:0] match_f(
        input logic [REG_ADDR_WIDTH-1:0]             src,
        input logic                                  use_src,
        input logic                                  valid,
        input logic [PIPE_DEPTH:1]                   v,
        input logic [PIPE_DEPTH:1][REG_ADDR_WIDTH-1:0] rd,
        input logic [PIPE_DEPTH:1]                   ld
    );
        logic                 found;
        logic [FWD_WIDTH-1:0] idx;
        logic                 is_ld;
        found = 1'b0;
        idx   = '0;
        is_ld = 1'b0;
        for (int k = 1; k <= PIPE_DEPTH; k++) begin
            if (!found && valid && use_src && (src != '0) && v[k] && (rd[k] == src)) begin
                found = 1'b1;
                idx   = FWD_WIDTH'(k);
                is_ld = ld[k];
            end
        end
        return {is_ld, idx};
    endfunction

    // A branch needs its operand one slot earlier than an EX consumer does.
    function automatic logic hazard_f(
        input logic [FWD_WIDTH-1:0] idx,
        input logic                 is_ld,
        input logic                 br
    );
        int k;
        k = int'(idx);
        return (k != 32'sd0) &&
               ((is_ld && (k < LOAD_LAT)) ||
                (br && (k == 32'sd1)) ||
                (br && is_ld && (k < LOAD_LAT + 32'sd1)));
    endfunction

    // Source matching, stall/flush and ID-comparator forward selects.
    always_comb begin
        {rs_ld_s, rs_match_s} = match_f(sb_if.id_rs, sb_if.id_useRs, sb_if.id_valid, v_q, rd_q, ld_q);
        {rt_ld_s, rt_match_s} = match_f(sb_if.id_rt, sb_if.id_useRt, sb_if.id_valid, v_q, rd_q, ld_q);
        stall_s = hazard_f(rs_match_s, rs_ld_s, sb_if.id_branch) |
                  hazard_f(rt_match_s, rt_ld_s, sb_if.id_branch);
        flush_s = sb_if.flush_req & ~stall_s;
    end

    assign sb_if.stall     = stall_s;
    assign sb_if.flush     = flush_s;
    assign sb_if.id_fwd_rs = sb_if.id_branch ? rs_match_s : '0;
    assign sb_if.id_fwd_rt = sb_if.id_branch ? rt_match_s : '0;
    assign sb_if.ex_fwd_rs = ex_fwd_rs_q;
    assign sb_if.ex_fwd_rt = ex_fwd_rt_q;

    // Next scoreboard contents: shift older, admit the ID producer (bubble on stall).
    always_comb begin
        v_d[1]  = sb_if.id_valid & ~stall_s & sb_if.id_regWrite & (sb_if.id_regToWrite != '0);
        rd_d[1] = sb_if.id_regToWrite;
        ld_d[1] = sb_if.id_memRead;
        for (int k = 2; k <= PIPE_DEPTH; k++) begin
            v_d[k]  = v_q[k-1];
            rd_d[k] = rd_q[k-1];
            ld_d[k] = ld_q[k-1];
        end
        if (stall_s) begin
            ex_fwd_rs_d = '0;
            ex_fwd_rt_d = '0;
        end else begin
            ex_fwd_rs_d = rs_match_s;
            ex_fwd_rt_d = rt_match_s;
        end
    end

    // Scoreboard and EX forward-select registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q         <= '0;
            rd_q        <= '0;
            ld_q        <= '0;
            ex_fwd_rs_q <= '0;
            ex_fwd_rt_q <= '0;
        end else begin
            v_q         <= v_d;
            rd_q        <= rd_d;
            ld_q        <= ld_d;
            ex_fwd_rs_q <= ex_fwd_rs_d;
            ex_fwd_rt_q <= ex_fwd_rt_d;
        end
    end

`ifdef HAZARD_SCOREBOARD_STATS_EN
    logic [31:0] stall_count_q;
    logic [31:0] stall_count_d;
    logic [31:0] flush_count_q;
    logic [31:0] flush_count_d;

    // Event counters wrap naturally at 2^32.
    always_comb begin
        if (stall_s) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
        if (flush_s) begin
            flush_count_d = flush_count_q + 32'd1;
        end else begin
            flush_count_d = flush_count_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count_q <= 32'd0;
            flush_count_q <= 32'd0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign sb_if.stall_count = stall_count_q;
    assign sb_if.flush_count = flush_count_q;
`else
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard (PIPE_DEPTH=3, LOAD_LAT=2) with an expected-value queue.
module tb_hazard_scoreboard;

    logic clk = 1'b0;
    logic rst;

    hazard_scoreboard_if #(.REG_ADDR_WIDTH(5), .FWD_WIDTH(2)) sb_if ();

    hazard_scoreboard #(
        .REG_ADDR_WIDTH(5),
        .PIPE_DEPTH    (3),
        .LOAD_LAT      (2),
        .FWD_WIDTH     (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .sb_if(sb_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%0d expected=<entry>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic id(input logic v, input int rs, input int rt, input logic urs, input logic urt,
                      input logic rw, input int rd, input logic mr, input logic br);
        sb_if.id_valid      = v;
        sb_if.id_rs         = 5'(rs);
        sb_if.id_rt         = 5'(rt);
        sb_if.id_useRs      = urs;
        sb_if.id_useRt      = urt;
        sb_if.id_regWrite   = rw;
        sb_if.id_regToWrite = 5'(rd);
        sb_if.id_memRead    = mr;
        sb_if.id_branch     = br;
    endtask

    task automatic nop();
        id(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    endtask

    // One ID cycle: combinational outputs mid-cycle, EX selects just after the edge.
    task automatic step(input int e_st, input int e_fl, input int e_ir, input int e_it,
                        input int e_er, input int e_et);
        push("stall", 32'(e_st));
        push("flush", 32'(e_fl));
        push("id_fwd_rs", 32'(e_ir));
        push("id_fwd_rt", 32'(e_it));
        push("ex_fwd_rs", 32'(e_er));
        push("ex_fwd_rt", 32'(e_et));
        #2;
        pop_chk(32'(sb_if.stall));
        pop_chk(32'(sb_if.flush));
        pop_chk(32'(sb_if.id_fwd_rs));
        pop_chk(32'(sb_if.id_fwd_rt));
        @(posedge clk);
        #1;
        pop_chk(32'(sb_if.ex_fwd_rs));
        pop_chk(32'(sb_if.ex_fwd_rt));
    endtask

    task automatic drain();
        nop();
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0;
        sb_if.flush_req = 1'b1;
        nop();
        // Reset state, including across a clock edge.
        #2;
        push("rst_stall", 32'd0); pop_chk(32'(sb_if.stall));
        push("rst_flush", 32'd1); pop_chk(32'(sb_if.flush));
        push("rst_ex_rs", 32'd0); pop_chk(32'(sb_if.ex_fwd_rs));
        #10;
        push("rst_ex_rt", 32'd0); pop_chk(32'(sb_if.ex_fwd_rt));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        push("rst_stall_count", 32'd0); pop_chk(sb_if.stall_count);
`endif
        rst = 1'b1;
        sb_if.flush_req = 1'b0;
        drain();

        // add r3 ; add r4,r3,r1
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 3, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 3, 1, 1'b1, 1'b1, 1'b1, 4, 1'b0, 1'b0); step(0, 0, 0, 0, 1, 0);
        drain();

        // lw r5 ; add r6,r1,r5
        id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0); step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2);
        drain();

        // add r0,r1,r2 ; add r7,r0,r0
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 0, 0, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        drain();

        // add r7 ; beq r7,r1 with flush_req held
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        sb_if.flush_req = 1'b1;
        id(1'b1, 7, 1, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1); step(1, 0, 1, 0, 0, 0);
        step(0, 1, 2, 0, 2, 0);
        sb_if.flush_req = 1'b0;
        drain();

        // add r8 ; add r8 ; add r9,r8,r8 -> youngest wins
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 8, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 8, 8, 1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0); step(0, 0, 0, 0, 1, 1);
        drain();

        // lw r10 ; beq r10,r2 -> two stall cycles, then forward from slot 3
        id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 10, 2, 1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b1); step(1, 0, 1, 0, 0, 0);
        step(1, 0, 2, 0, 0, 0);
        step(0, 0, 3, 0, 3, 0);
        drain();

        // invalid ID slot never matches, never stalls, never enters the scoreboard
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 11, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b0, 11, 11, 1'b1, 1'b1, 1'b1, 12, 1'b1, 1'b1); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 12, 0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        drain();

        // add r12 ; lw r5,0(r12) ; add r6,r1,r5 with reset pulsed mid-stall
        id(1'b1, 1, 2, 1'b1, 1'b1, 1'b1, 12, 1'b0, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 12, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0); step(0, 0, 0, 0, 1, 0);
        id(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0);
        #2;
        push("pre_rst_stall", 32'd1); pop_chk(32'(sb_if.stall));
        #1;
        rst = 1'b0;
        sb_if.flush_req = 1'b1;
        #1;
        push("mid_rst_stall", 32'd0); pop_chk(32'(sb_if.stall));
        push("mid_rst_flush", 32'd1); pop_chk(32'(sb_if.flush));
        push("mid_rst_ex_rs", 32'd0); pop_chk(32'(sb_if.ex_fwd_rs));
        push("mid_rst_ex_rt", 32'd0); pop_chk(32'(sb_if.ex_fwd_rt));
`ifdef HAZARD_SCOREBOARD_STATS_EN
        push("mid_rst_stall_count", 32'd0); pop_chk(sb_if.stall_count);
`endif
        @(posedge clk);
        #1;
        push("held_rst_ex_rs", 32'd0); pop_chk(32'(sb_if.ex_fwd_rs));
        rst = 1'b1;
        sb_if.flush_req = 1'b0;
        id(1'b1, 1, 0, 1'b1, 1'b0, 1'b1, 5, 1'b1, 1'b0); step(0, 0, 0, 0, 0, 0);
        id(1'b1, 1, 5, 1'b1, 1'b1, 1'b1, 6, 1'b0, 1'b0); step(1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 2);
`ifdef HAZARD_SCOREBOARD_STATS_EN
        push("post_rst_stall_count", 32'd1); pop_chk(sb_if.stall_count);
`endif
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised hazard-detection and forwarding-control block for the pipelined MIPS datapath.
- Holds a shift-register scoreboard of in-flight destination registers, one slot per stage after ID.
- Drives the load-use and branch-operand stall, the IF/ID flush, ID-stage forward selects (branch compare) and registered EX-stage forward selects.
- Sits beside the controller in ID and replaces the fixed no-hazard assumption of the current pipeline.

Parameters:
- REG_ADDR_WIDTH, 5: register address width.
- PIPE_DEPTH, 3: tracked stages after ID. Slot 1 = EX … slot PIPE_DEPTH = WB. Range 2..7.
- LOAD_LAT, 2: first slot index whose load result is forwardable. Range 1..PIPE_DEPTH.
- FWD_WIDTH, 2: forward-select width. Must satisfy 2^FWD_WIDTH > PIPE_DEPTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  REG_ADDR_WIDTH  source registers in ID.
- id_useRs, id_useRt  in  1  source actually read.
- id_regWrite  in  1  ID instruction writes a register.
- id_regToWrite  in  REG_ADDR_WIDTH  destination in ID.
- id_memRead  in  1  ID instruction is a load.
- id_branch  in  1  ID instruction compares operands in ID (beq/bne).
- flush_req  in  1  branch taken / jump / jal / jr resolved this cycle.
- stall  out  1  hold PC and IF/ID; inject bubble into ID/EX. Combinational.
- flush  out  1  bubble IF/ID. Combinational.
- id_fwd_rs, id_fwd_rt  out  FWD_WIDTH  forward select for the ID comparator. Combinational.
- ex_fwd_rs, ex_fwd_rt  out  FWD_WIDTH  forward select for EX operands. Registered.

Behaviour:
- Scoreboard slot k holds {v, rd, ld}.
  - Each edge: slot k+1 <= slot k for k = 1..PIPE_DEPTH-1; the slot PIPE_DEPTH entry retires.
  - Slot 1 <= {id_valid & ~stall & id_regWrite & (id_regToWrite != 0), id_regToWrite, id_memRead}.
  - While stalled, slot 1 loads invalid (bubble); older slots still advance.
- Match for source s: the smallest k with v_k & rd_k == s & s != 0 & use_s & id_valid. Register 0 never matches.
- Forward encoding: 0 = regfile; k = result of the producer matched in slot k at ID time.
  - On the next edge, without stall: ex_fwd_* <= match index. With stall: ex_fwd_* <= 0.
  - Code PIPE_DEPTH selects the datapath's one-cycle retired-result latch, because the regfile write and the ID read happen in the same cycle.
- id_fwd_* = match index when id_branch, else 0.
- stall = 1 if any used source has match k with:
  - ld_k & k < LOAD_LAT; or
  - id_branch & k == 1; or
  - id_branch & ld_k & k < LOAD_LAT+1.
- flush = flush_req & ~stall.
  - When stall and flush_req coincide, stall wins: flush is 0 and the datapath re-presents the branch the next cycle.
- Latency:
  - stall, flush, id_fwd_*: 0 cycles.
  - ex_fwd_*: 1 cycle.
  - A load-use hazard stalls exactly LOAD_LAT-1 cycles. A branch behind an ALU producer stalls 1 cycle.
- id_valid=0 contributes a bubble and never raises stall.
- Reset (rst low, asynchronous, any time including mid-stall):
  - All slots invalid; ex_fwd_* = 0.
  - stall = 0 and flush = flush_req, since no matches are possible.
  - Normal operation resumes on the first edge after rst rises.
- Oldest-wins is forbidden: the youngest producer always takes priority.

Optional Feature:
- Macro HAZARD_SCOREBOARD_STATS_EN.
- Defined: adds outputs stall_count[31:0] and flush_count[31:0].
  - Each increments by 1 on every edge where stall (resp. flush) is 1.
  - They wrap at 2^32-1 to 0 and reset to 0 on rst low.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- PIPE_DEPTH=3, LOAD_LAT=2 throughout.
- add r3 followed by add r4,r3,r1 → stall=0 throughout; ex_fwd_rs=1 on the edge the second add enters EX; ex_fwd_rt=0.
- lw r5 followed by add r6,r1,r5 → stall=1 for exactly 1 cycle; slot 1 gets a bubble; ex_fwd_rt=2 when the add enters EX.
- add r0,r1,r2 followed by add r7,r0,r0 → no match; stall=0; ex_fwd_*=0.
- add r7 followed by beq r7,r1 with flush_req=1 held → cycle 1: stall=1, flush=0. Cycle 2: stall=0, id_fwd_rs=2, flush=1.
- add r8; add r8; add r9,r8,r8 → both selects resolve to slot 1 (youngest): ex_fwd_rs=ex_fwd_rt=1.
- lw r5; add r6,r5 with rst pulsed low mid-stall → stall=0 and ex_fwd_*=0 immediately, before any clock edge; with STATS_EN, stall_count=0; after release, the same lw/add pair stalls 1 cycle again.
